// File: rtl/chip_top_lite.sv
// chip_top_lite: minimal chip-level top with a UART console.
//   - Conditions rst_top into an internal core reset (async assert, 2-flop sync release).
//   - Transmits BOOT_BYTE once after every reset release.
//   - Receives 8N1 bytes, shows the last good byte on led, flags framing errors.
//   - Optional macro UART_ECHO_EN: echoes every good received byte back on txd.
//
// Ports:
//   clk_p   in   board clock, rising edge, the only clock used
//   clk_n   in   complement of clk_p, no functional use
//   rst_top in   asynchronous active-high board reset
//   rxd     in   UART receive (asynchronous, idles high)
//   txd     out  UART transmit (idles high)
//   led     out  [7:0] last correctly framed received byte
//   rx_err  out  sticky framing-error flag
//
// TX FSM
//   state    | meaning
//   TX_IDLE  | line high, waiting for the holding register to fill
//   TX_START | driving start bit (0)
//   TX_DATA  | driving data bits 0..7, LSB first
//   TX_STOP  | driving stop bit (1); chains straight into TX_START if a byte waits
//
// RX FSM
//   state    | meaning
//   RX_IDLE  | waiting for a synchronized 1->0 edge
//   RX_START | counting to the start-bit centre, rejects false starts
//   RX_DATA  | sampling data bits at bit centres
//   RX_STOP  | sampling the stop bit, commits byte or flags framing error
module chip_top_lite #(
  parameter int         CLK_DIV   = 868,
  parameter logic [7:0] BOOT_BYTE = 8'h42
) (
  input  logic       clk_p,
  input  logic       clk_n,
  input  logic       rst_top,
  input  logic       rxd,
  output logic       txd,
  output logic [7:0] led,
  output logic       rx_err
);

  localparam logic [11:0] DIV_M1  = 12'(CLK_DIV - 1);
  localparam logic [11:0] HALF_M1 = 12'(CLK_DIV / 2 - 1);

  // Core reset: asserts with rst_top, releases on the 2nd clock edge after it falls.
  logic rst_meta;
  logic rst_core;

  always_ff @(posedge clk_p or posedge rst_top) begin
    if (rst_top) begin
      rst_meta <= 1'b1;
      rst_core <= 1'b1;
    end else begin
      rst_meta <= 1'b0;
      rst_core <= rst_meta;
    end
  end

  // Receiver
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t   rx_state;
  logic        rxd_meta;
  logic        rxd_sync;
  logic        rxd_prev;
  logic [11:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_valid;

  always_ff @(posedge clk_p or posedge rst_core) begin
    if (rst_core) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= 12'd0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'h00;
      rx_valid <= 1'b0;
      led      <= 8'h00;
      rx_err   <= 1'b0;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
      rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rxd_prev && !rxd_sync) begin
            rx_state <= RX_START;
            rx_cnt   <= HALF_M1;
          end
        end
        RX_START: begin
          if (rx_cnt == 12'd0) begin
            if (rxd_sync) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_state <= RX_DATA;
              rx_cnt   <= DIV_M1;
              rx_bit   <= 3'd0;
            end
          end else begin
            rx_cnt <= rx_cnt - 12'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == 12'd0) begin
            rx_shift <= {rxd_sync, rx_shift[7:1]};
            rx_cnt   <= DIV_M1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt - 12'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == 12'd0) begin
            if (rxd_sync) begin
              led      <= rx_shift;
              rx_valid <= 1'b1;
            end else begin
              rx_err <= 1'b1;
            end
            rx_state <= RX_IDLE;
          end else begin
            rx_cnt <= rx_cnt - 12'd1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Transmitter with a 1-deep holding register
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t   tx_state;
  logic [11:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        boot_pending;
  logic        hold_full;
  logic [7:0]  hold_data;
  logic        hold_take;
  logic        hold_accept;
  logic        wr_req;
  logic [7:0]  wr_data;

`ifdef UART_ECHO_EN
  // Boot byte only competes on the first cycle after release, before any rx_valid.
  assign wr_req  = boot_pending | rx_valid;
  assign wr_data = boot_pending ? BOOT_BYTE : led;
  logic unused_clk_n;
  assign unused_clk_n = clk_n;
`else
  assign wr_req  = boot_pending;
  assign wr_data = BOOT_BYTE;
  logic unused_sig;
  assign unused_sig = clk_n ^ rx_valid;
`endif

  // The FSM consumes the held byte when idle or at the very end of a stop bit.
  assign hold_take   = hold_full &&
                       ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && (tx_cnt == 12'd0)));
  assign hold_accept = wr_req && (!hold_full || hold_take);

  always_ff @(posedge clk_p or posedge rst_core) begin
    if (rst_core) begin
      boot_pending <= 1'b1;
      hold_full    <= 1'b0;
      hold_data    <= 8'h00;
      tx_state     <= TX_IDLE;
      tx_cnt       <= 12'd0;
      tx_bit       <= 3'd0;
      tx_shift     <= 8'h00;
      txd          <= 1'b1;
    end else begin
      boot_pending <= 1'b0;
      if (hold_accept) begin
        hold_full <= 1'b1;
        hold_data <= wr_data;
      end else if (hold_take) begin
        hold_full <= 1'b0;
      end

      case (tx_state)
        TX_IDLE: begin
          if (hold_full) begin
            tx_state <= TX_START;
            tx_shift <= hold_data;
            tx_cnt   <= DIV_M1;
            txd      <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_cnt == 12'd0) begin
            tx_state <= TX_DATA;
            tx_cnt   <= DIV_M1;
            tx_bit   <= 3'd0;
            txd      <= tx_shift[0];
          end else begin
            tx_cnt <= tx_cnt - 12'd1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == 12'd0) begin
            tx_cnt <= DIV_M1;
            if (tx_bit == 3'd7) begin
              tx_state <= TX_STOP;
              txd      <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              txd      <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt - 12'd1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == 12'd0) begin
            if (hold_full) begin
              tx_state <= TX_START;
              tx_shift <= hold_data;
              tx_cnt   <= DIV_M1;
              txd      <= 1'b0;
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt - 12'd1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chip_top_lite.sv
// Self-checking bench for chip_top_lite with CLK_DIV=16.
// Expected line states come from an abstract UART model (frame bit lists and
// last-good-byte / sticky-error variables), not from the design's internals.
module tb_chip_top_lite;
  localparam int DIV = 16;

  logic       clk_p = 1'b0;
  logic       clk_n;
  logic       rst_top;
  logic       rxd;
  logic       txd;
  logic       rx_err;
  logic [7:0] led;

  int         total = 0;
  int         passed = 0;
  logic [7:0] exp_led = 8'h00;
  logic       exp_err = 1'b0;

  assign clk_n = ~clk_p;
  always #5 clk_p = ~clk_p;

  chip_top_lite #(.CLK_DIV(DIV), .BOOT_BYTE(8'h42)) dut (
    .clk_p  (clk_p),
    .clk_n  (clk_n),
    .rst_top(rst_top),
    .rxd    (rxd),
    .txd    (txd),
    .led    (led),
    .rx_err (rx_err)
  );

  // Line level of an 8N1 frame at bit slot idx (0 = start, 1..8 = data, 9 = stop).
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    logic [7:0] v;
    v = b;
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return v[idx-1];
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_p);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit, input int idle);
    for (int i = 0; i < 10; i++) begin
      rxd = (i == 9) ? stop_bit : frame_bit(b, i);
      cycles(DIV);
    end
    rxd = 1'b1;
    cycles(idle);
  endtask

  // Waits (bounded) for a start bit, then samples every bit at its centre.
  task automatic capture_tx(output logic [7:0] b, output logic ok, output int lat,
                            input int limit);
    ok  = 1'b0;
    lat = 0;
    b   = 8'h00;
    while (txd !== 1'b0 && lat < limit) begin
      @(negedge clk_p);
      lat++;
    end
    if (txd !== 1'b0) return;
    cycles(DIV / 2);
    if (txd !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin
      cycles(DIV);
      b[i] = txd;
    end
    cycles(DIV);
    ok = (txd === 1'b1);
  endtask

  task automatic test_reset();
    int bad;
    int first_bad;
    logic exp_l;
    rst_top = 1'b1;
    rxd     = 1'b1;
    cycles(6);
    total++;
    if (txd !== 1'b1 || led !== 8'h00 || rx_err !== 1'b0)
      $display("FAIL reset_values txd=%b led=%h rx_err=%b required txd=1 led=00 rx_err=0",
               txd, led, rx_err);
    else passed++;
    cycles(7);
    rst_top = 1'b0;
    cycles(3);
    total++;
    if (txd !== 1'b1) $display("FAIL boot_not_early txd=%b required 1", txd);
    else passed++;
    cycles(1);
    total++;
    if (txd !== 1'b0) $display("FAIL boot_start_edge txd=%b required 0", txd);
    else passed++;
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < 10 * DIV + 8; i++) begin
      exp_l = (i < 10 * DIV) ? frame_bit(8'h42, i / DIV) : 1'b1;
      if (txd !== exp_l) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
      cycles(1);
    end
    total++;
    if (bad != 0)
      $display("FAIL boot_waveform mismatching_cycles=%0d first_at=%0d required 0", bad, first_bad);
    else passed++;
  endtask

  task automatic test_rx_basic();
    logic [7:0] b;
    logic       ok;
    int         lat;
    fork
      send_rx(8'hA5, 1'b1, 4);
      capture_tx(b, ok, lat, 400);
    join
    exp_led = 8'hA5;
    total++;
    if (led !== exp_led || rx_err !== exp_err)
      $display("FAIL rx_basic led=%h rx_err=%b required led=%h rx_err=%b", led, rx_err, exp_led, exp_err);
    else passed++;
`ifdef UART_ECHO_EN
    total++;
    if (!ok || b !== 8'hA5) $display("FAIL echo_byte ok=%b byte=%h required ok=1 byte=a5", ok, b);
    else passed++;
    total++;
    if (lat < 155 || lat > 159) $display("FAIL echo_latency cycles=%0d required 155..159", lat);
    else passed++;
`else
    total++;
    if (ok) $display("FAIL no_echo frame_seen byte=%h required no frame", b);
    else passed++;
`endif
  endtask

  task automatic test_framing();
    send_rx(8'h3C, 1'b0, 4);
    exp_err = 1'b1;
    total++;
    if (led !== exp_led || rx_err !== exp_err)
      $display("FAIL framing_err led=%h rx_err=%b required led=%h rx_err=%b", led, rx_err, exp_led, exp_err);
    else passed++;
    send_rx(8'h11, 1'b1, 4);
    exp_led = 8'h11;
    total++;
    if (led !== exp_led || rx_err !== exp_err)
      $display("FAIL framing_recover led=%h rx_err=%b required led=%h rx_err=%b", led, rx_err, exp_led, exp_err);
    else passed++;
  endtask

  task automatic test_glitch();
    int lens [3] = '{4, 1, 5};
    for (int i = 0; i < 3; i++) begin
      rxd = 1'b0;
      cycles(lens[i]);
      rxd = 1'b1;
      cycles(2 * DIV);
      total++;
      if (led !== exp_led || rx_err !== exp_err)
        $display("FAIL glitch_len%0d led=%h rx_err=%b required led=%h rx_err=%b",
                 lens[i], led, rx_err, exp_led, exp_err);
      else passed++;
    end
  endtask

  task automatic test_random();
    int         kind;
    logic [7:0] b;
    for (int i = 0; i < 10; i++) begin
      kind = int'($urandom_range(0, 2));
      b    = 8'($urandom);
      if (kind == 0) begin
        send_rx(b, 1'b1, 4);
        exp_led = b;
      end else if (kind == 1) begin
        send_rx(b, 1'b0, 4);
        exp_err = 1'b1;
      end else begin
        rxd = 1'b0;
        cycles(int'($urandom_range(1, 5)));
        rxd = 1'b1;
        cycles(2 * DIV);
      end
      total++;
      if (led !== exp_led || rx_err !== exp_err)
        $display("FAIL random_%0d kind=%0d byte=%h led=%h rx_err=%b required led=%h rx_err=%b",
                 i, kind, b, led, rx_err, exp_led, exp_err);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a;
    logic [7:0] c;
    logic [7:0] b1;
    logic [7:0] b2;
    logic       ok1;
    logic       ok2;
    int         lat1;
    int         lat2;
    cycles(400);
    a = 8'($urandom);
    c = 8'($urandom);
    fork
      begin
        send_rx(a, 1'b1, 0);
        send_rx(c, 1'b1, 4);
      end
      begin
        capture_tx(b1, ok1, lat1, 400);
        capture_tx(b2, ok2, lat2, 400);
      end
    join
    exp_led = c;
    total++;
    if (led !== exp_led || rx_err !== exp_err)
      $display("FAIL b2b_led led=%h rx_err=%b required led=%h rx_err=%b", led, rx_err, exp_led, exp_err);
    else passed++;
`ifdef UART_ECHO_EN
    total++;
    if (!ok1 || b1 !== a || !ok2 || b2 !== c)
      $display("FAIL b2b_echo got %b/%h %b/%h required 1/%h 1/%h", ok1, b1, ok2, b2, a, c);
    else passed++;
    total++;
    if (lat2 != DIV / 2) $display("FAIL b2b_gap wait=%0d required %0d", lat2, DIV / 2);
    else passed++;
`else
    total++;
    if (ok1 || ok2) $display("FAIL b2b_no_echo frames=%b%b required 00", ok1, ok2);
    else passed++;
`endif
  endtask

  task automatic test_reset_mid_tx();
    logic [7:0] b;
    logic       ok;
    int         lat;
    rst_top = 1'b1;
    #1;
    total++;
    if (txd !== 1'b1 || led !== 8'h00 || rx_err !== 1'b0)
      $display("FAIL reset_clears txd=%b led=%h rx_err=%b required txd=1 led=00 rx_err=0", txd, led, rx_err);
    else passed++;
    exp_led = 8'h00;
    exp_err = 1'b0;
    @(negedge clk_p);
    cycles(3);
    rst_top = 1'b0;
    lat = 0;
    while (txd !== 1'b0 && lat < 20) begin
      @(negedge clk_p);
      lat++;
    end
    total++;
    if (lat != 4) $display("FAIL boot_restart latency=%0d required 4", lat);
    else passed++;
    cycles(5);
    total++;
    if (txd !== 1'b0) $display("FAIL mid_tx_low txd=%b required 0", txd);
    else passed++;
    #2;
    rst_top = 1'b1;
    #1;
    total++;
    if (txd !== 1'b1) $display("FAIL async_abort txd=%b required 1", txd);
    else passed++;
    cycles(3);
    rst_top = 1'b0;
    capture_tx(b, ok, lat, 50);
    total++;
    if (!ok || b !== 8'h42 || lat != 4)
      $display("FAIL boot_retransmit ok=%b byte=%h latency=%0d required ok=1 byte=42 latency=4", ok, b, lat);
    else passed++;
    total++;
    if (led !== exp_led || rx_err !== exp_err)
      $display("FAIL post_reset led=%h rx_err=%b required led=%h rx_err=%b", led, rx_err, exp_led, exp_err);
    else passed++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rx_basic();
    test_framing();
    test_glitch();
    test_random();
    test_back_to_back();
    test_reset_mid_tx();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/chip_top_lite.md
Name: chip_top_lite

Overview:
Minimal chip-level top: one board clock, board reset, and a UART console.
- Conditions the board reset into a core reset: asynchronous assert, synchronous release.
- Sends a boot byte on the UART after reset release.
- Receives 8N1 bytes and shows the last good byte on LEDs.
- Optionally echoes each received byte back on txd.

Parameters:
CLK_DIV, 868, clk_p cycles per UART bit (100 MHz / 115200); legal range 4..4095.
BOOT_BYTE, 8'h42, byte transmitted once after each reset release.

Ports:
clk_p  input  1  board clock, rising edge; the single clock of the block.
clk_n  input  1  complement of clk_p from the differential pair; unused internally.
rst_top  input  1  asynchronous, active-high board reset.
rxd  input  1  UART receive, asynchronous to clk_p, idles high.
txd  output  1  UART transmit, idles high.
led  output  8  last correctly framed received byte.
rx_err  output  1  sticky framing-error flag.

Behaviour:
Reset and clocking:
- One clock (clk_p); reset is asynchronous and active-high on rst_top.
- Internal reset asserts immediately when rst_top rises.
- Internal reset deasserts on the 2nd clk_p rising edge after rst_top falls (2-flop synchronizer).
- While internal reset is asserted: txd=1, led=0, rx_err=0, all counters 0, TX holding register empty, RX FSM in IDLE.
- Reset asserted mid-frame aborts both directions immediately; txd returns to 1 asynchronously.
Boot byte:
- The cycle after internal reset release, BOOT_BYTE is loaded into the TX holding register.
- Its start bit begins on the following cycle.
UART frame format (both directions): 8N1, LSB first, 1 bit = CLK_DIV cycles, 1 frame = 10*CLK_DIV cycles.
TX path:
- Shift FSM states IDLE, START, DATA(0..7), STOP.
- Leaves IDLE the cycle after the holding register becomes full; the holding register empties on the same cycle.
- A single 1-deep holding register feeds the FSM.
- If a new byte arrives while the holding register is full, the new byte is dropped.
- A new frame may start the cycle after STOP completes, so frames are back-to-back with no idle gap.
RX path:
- rxd passes through a 2-flop synchronizer.
- FSM states IDLE, START, DATA, STOP.
- IDLE -> START on synchronized 1->0 transition.
- At CLK_DIV/2 cycles (integer division) the line is re-sampled; if high, false start, return to IDLE.
- Data bits are sampled every CLK_DIV cycles at bit centres.
- Stop bit sampled 1: latch byte into led, pulse internal rx_valid for 1 cycle, return to IDLE.
- Stop bit sampled 0: rx_err <= 1 (sticky until reset), led unchanged, no rx_valid, return to IDLE.
- A following start edge is accepted only after the RX FSM is back in IDLE.
Simultaneous events:
- If rx_valid coincides with the holding register emptying, the echo byte is accepted.
- Boot byte takes priority over echo on the first cycle after reset; the echo can never collide with it, because no frame can complete in 1 cycle.
clk_n has no functional effect.

Optional Feature:
Macro UART_ECHO_EN.
- Defined: every rx_valid byte is offered to the TX holding register, subject to the drop-when-full rule.
- Undefined: received bytes only update led; txd carries only the boot byte. The echo path and its mux are not synthesized.

Test Plan:
1. CLK_DIV=16, rst_top high for 130 ns, then low -> txd=1 during reset; internal reset releases 2 edges after rst_top falls; txd shows frame 0,0,1,0,0,0,0,1,0,1 (0x42 LSB first), 16 cycles per bit, then idles at 1.
2. Drive 8N1 byte 0xA5 on rxd at 16 cycles/bit -> led=0xA5 after mid-stop sample; rx_err=0.
3. Same as 2 with UART_ECHO_EN -> txd emits 0xA5 frame starting 1-3 cycles after rx_valid.
4. Drive byte 0x3C with stop bit 0 -> rx_err=1, led keeps previous value; a subsequent valid 0x11 gives led=0x11 and rx_err stays 1.
5. rxd low glitch of 4 cycles -> no byte; led and rx_err unchanged.
6. Assert rst_top mid-TX-frame -> txd=1 immediately and led=0; after release the boot byte 0x42 is retransmitted.
